// File: rtl/wbs_mem_ctrl.sv
// wbs_mem_ctrl
// Wishbone slave front end for the KD-tree ANN accelerator. Decodes the
// Caravel bus into control registers and the query/leaf/best/node memories,
// pairs two 32-bit bus words into one 64-bit row write, sequences the
// synchronous best-memory read and returns a single-cycle acknowledge.
module wbs_mem_ctrl #(
  parameter int DATA_WIDTH   = 11,
  parameter int NODE_ADDR_W  = 6,
  parameter int LEAF_ADDR_W  = 9,
  parameter int QUERY_ADDR_W = 12,
  parameter int BEST_ADDR_W  = 9
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  output logic                      node_we,
  output logic [NODE_ADDR_W-1:0]    node_addr,
  output logic [2*DATA_WIDTH-1:0]   node_wdata,
  output logic                      leaf_we,
  output logic [LEAF_ADDR_W-1:0]    leaf_addr,
  output logic [63:0]               leaf_wdata,
  output logic                      query_we,
  output logic [QUERY_ADDR_W-1:0]   query_addr,
  output logic [5*DATA_WIDTH-1:0]   query_wdata,
  output logic                      best_re,
  output logic [BEST_ADDR_W-1:0]    best_addr,
  input  logic [63:0]               best_rdata,
  output logic                      fsm_start,
  input  logic                      fsm_busy,
  input  logic                      fsm_done,
  output logic                      wbs_mode,
  output logic                      wbs_debug
);

  localparam int QUERY_W = 5 * DATA_WIDTH;
  localparam int NODE_W  = 2 * DATA_WIDTH;

  // Bus transaction states
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_RWAIT = 3'd2;
  localparam logic [2:0] S_WACK  = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;

  // Region select on adr[31:16]
  localparam logic [15:0] REG_CTRL  = 16'h3000;
  localparam logic [15:0] REG_QUERY = 16'h3001;
  localparam logic [15:0] REG_LEAF  = 16'h3002;
  localparam logic [15:0] REG_BEST  = 16'h3003;
  localparam logic [15:0] REG_NODE  = 16'h3004;

  // Control register offsets on adr[4:0]
  localparam logic [4:0] OFF_MODE  = 5'h00;
  localparam logic [4:0] OFF_DEBUG = 5'h04;
  localparam logic [4:0] OFF_DONE  = 5'h08;
  localparam logic [4:0] OFF_START = 5'h0C;
  localparam logic [4:0] OFF_BUSY  = 5'h10;

  logic [2:0]  state;
  logic [31:0] hold;
  logic        done_flag;
  logic        err_flag;
  logic        rd_word_hi;
  // Control-register writes land one edge after the request is sampled.
  logic        pend_mode;
  logic        pend_debug;
  logic        pend_err_clr;
  logic        pend_bit;

  logic        sample;
  logic        is_ctrl, is_query, is_leaf, is_best, is_node, is_mem_wr;
  logic        busy_drop;
  logic [63:0] row_word;
  logic [31:0] reg_rdata;

  // Byte enables and the address bit between the row field and the region
  // field carry no meaning for this slave.
  logic unused_ok;
  assign unused_ok = &{1'b0, wbs_sel_i, wbs_adr_i[15]};

  // Request decode and control-register read mux
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    reg_rdata = '0;
    sample    = (state == S_IDLE) && wbs_stb_i && wbs_cyc_i;
    is_ctrl   = (wbs_adr_i[31:16] == REG_CTRL);
    is_query  = (wbs_adr_i[31:16] == REG_QUERY);
    is_leaf   = (wbs_adr_i[31:16] == REG_LEAF);
    is_best   = (wbs_adr_i[31:16] == REG_BEST);
    is_node   = (wbs_adr_i[31:16] == REG_NODE);
    is_mem_wr = is_query || is_leaf || is_node;
    row_word  = {wbs_dat_i, hold};
    busy_drop = sample && wbs_we_i && is_mem_wr && fsm_busy;
    if (is_ctrl) begin
      case (wbs_adr_i[4:0])
        OFF_MODE:  reg_rdata[0]   = wbs_mode;
        OFF_DEBUG: reg_rdata[0]   = wbs_debug;
        OFF_DONE:  reg_rdata[1:0] = {err_flag, done_flag};
        OFF_BUSY:  reg_rdata[0]   = fsm_busy;
        default:   reg_rdata      = '0;
      endcase
    end
  end

  // Bus state machine, memory write strobes and read data capture
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= S_IDLE;
      hold         <= '0;
      rd_word_hi   <= 1'b0;
      pend_mode    <= 1'b0;
      pend_debug   <= 1'b0;
      pend_err_clr <= 1'b0;
      pend_bit     <= 1'b0;
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      node_we      <= 1'b0;
      node_addr    <= '0;
      node_wdata   <= '0;
      leaf_we      <= 1'b0;
      leaf_addr    <= '0;
      leaf_wdata   <= '0;
      query_we     <= 1'b0;
      query_addr   <= '0;
      query_wdata  <= '0;
      best_re      <= 1'b0;
      best_addr    <= '0;
      fsm_start    <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults make every strobe a one-cycle pulse;
      // a later assignment in the same block overrides the default.
      wbs_ack_o    <= 1'b0;
      node_we      <= 1'b0;
      leaf_we      <= 1'b0;
      query_we     <= 1'b0;
      best_re      <= 1'b0;
      fsm_start    <= 1'b0;
      pend_mode    <= 1'b0;
      pend_debug   <= 1'b0;
      pend_err_clr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sample) begin
            if (!wbs_we_i && is_best) begin
              state      <= S_RD;
              best_re    <= 1'b1;
              best_addr  <= wbs_adr_i[BEST_ADDR_W+2:3];
              rd_word_hi <= wbs_adr_i[2];
            end else begin
              state     <= S_WACK;
              wbs_ack_o <= 1'b1;
              if (!wbs_we_i) begin
                wbs_dat_o <= reg_rdata;
              end else if (is_ctrl) begin
                pend_bit <= wbs_dat_i[0];
                case (wbs_adr_i[4:0])
                  OFF_MODE:  pend_mode    <= 1'b1;
                  OFF_DEBUG: pend_debug   <= 1'b1;
                  OFF_DONE:  pend_err_clr <= 1'b1;
                  OFF_START: fsm_start    <= 1'b1;
                  default:   ;
                endcase
              end else if (is_mem_wr && !fsm_busy) begin
                if (is_node) begin
                  node_we    <= 1'b1;
                  node_addr  <= wbs_adr_i[NODE_ADDR_W-1:0];
                  node_wdata <= wbs_dat_i[NODE_W-1:0];
                end else if (!wbs_adr_i[2]) begin
                  hold <= wbs_dat_i;
                end else if (is_leaf) begin
                  leaf_we    <= 1'b1;
                  leaf_addr  <= wbs_adr_i[LEAF_ADDR_W+2:3];
                  leaf_wdata <= row_word;
                end else begin
                  query_we    <= 1'b1;
                  query_addr  <= wbs_adr_i[QUERY_ADDR_W+2:3];
                  query_wdata <= row_word[QUERY_W-1:0];
                end
              end
            end
          end
        end
        S_RD:    state <= S_RWAIT;
        S_RWAIT: begin
          state     <= S_ACK;
          wbs_ack_o <= 1'b1;
          wbs_dat_o <= rd_word_hi ? best_rdata[63:32] : best_rdata[31:0];
        end
        S_WACK, S_ACK: state <= S_IDLE;
        default:       state <= S_IDLE;
      endcase
    end
  end

  // Configuration bits and FSM status flags
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_mode  <= 1'b0;
      wbs_debug <= 1'b0;
      done_flag <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      if (pend_mode)  wbs_mode  <= pend_bit;
      if (pend_debug) wbs_debug <= pend_bit;
      // A completion arriving together with a new start still reports done.
      if (fsm_done)       done_flag <= 1'b1;
      else if (fsm_start) done_flag <= 1'b0;
      if (busy_drop)         err_flag <= 1'b1;
      else if (pend_err_clr) err_flag <= 1'b0;
    end
  end

endmodule
